// File: rtl/z80_bus_arbiter.sv
// Z80 bus arbiter: hands the external bus between the Z80 core and one DMA master over nBUSRQ/nBUSACK.
// Outputs registered one CLK after the sampled inputs; a pending DMA request waits in REQ/GAP until served.
module z80_bus_arbiter #(
    parameter int MAX_BURST   = 16,
    parameter int MIN_GAP     = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       dma_req,
    input  logic       dma_done,
    input  logic       nBUSACK,
    output logic       nBUSRQ,
    output logic       dma_gnt,
    output logic       bus_sel,
    output logic [7:0] burst_cnt,
    output logic       timeout_err,
    input  logic       err_clr
);
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);
    localparam logic [7:0] GAP_LEN   = 8'(MIN_GAP);
    localparam logic [7:0] ACK_LIM   = 8'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_GRANT,
        S_TURN,
        S_RELEASE,
        S_GAP
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       nbusrq_q, nbusrq_d;
    logic       gnt_q, gnt_d;
    logic       err_q, err_d;
    logic       tmo_set;
    logic [7:0] wait_inc, gap_inc, burst_inc;

    assign wait_inc  = wait_cnt_q + 8'd1;
    assign gap_inc   = gap_cnt_q + 8'd1;
    assign burst_inc = burst_cnt_q + 8'd1;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            burst_cnt_q <= '0;
            nbusrq_q    <= 1'b1;
            gnt_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            nbusrq_q    <= nbusrq_d;
            gnt_q       <= gnt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        burst_cnt_d = burst_cnt_q;
        nbusrq_d    = nbusrq_q;
        gnt_d       = gnt_q;
        tmo_set     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                wait_cnt_d = '0;
                if (dma_req) begin
                    state_d  = S_REQ;
                    nbusrq_d = 1'b0;
                end
            end
            S_REQ: begin
                wait_cnt_d = wait_inc;
                // A withdrawn request beats a simultaneous acknowledge: never grant a master that left.
                if (!dma_req) begin
                    state_d = S_TURN;
                end else if (!nBUSACK) begin
                    state_d     = S_GRANT;
                    gnt_d       = 1'b1;
                    burst_cnt_d = 8'd1;
                end else if (wait_inc >= ACK_LIM) begin
                    tmo_set = 1'b1;
                    state_d = S_TURN;
                end
            end
            S_GRANT: begin
                // nBUSACK rising here is a Z80 protocol violation; leave quietly without flagging.
                if (!dma_req || dma_done || nBUSACK || (burst_cnt_q >= BURST_MAX)) begin
                    state_d     = S_TURN;
                    gnt_d       = 1'b0;
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_inc;
                end
            end
            S_TURN: begin
                nbusrq_d = 1'b1;
                state_d  = S_RELEASE;
            end
            S_RELEASE: begin
                gap_cnt_d = '0;
                if (nBUSACK) begin
                    state_d = (GAP_LEN == 8'd0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_inc;
                if (gap_inc >= GAP_LEN) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        err_d = tmo_set | (err_q & ~err_clr);
    end

    assign nBUSRQ      = nbusrq_q;
    assign dma_gnt     = gnt_q;
    assign bus_sel     = gnt_q;
    assign burst_cnt   = burst_cnt_q;
    assign timeout_err = err_q;

endmodule

// File: doc/z80_bus_arbiter.md
Name: z80_bus_arbiter

Overview:
- Shares the Z80 external bus (A, D, control pins) between the CPU core and one DMA master using the Z80 nBUSRQ/nBUSACK handshake.
- Sequences the full hand-over: request, acknowledge, grant, turnaround, release and a CPU fairness gap.
- Drives the bus-ownership select used by the board-level A/D/control mux.
- Sits beside the Z80 top level, in the same clock domain as the core.

Parameters:
MAX_BURST, 16, max consecutive CLK cycles DMA may hold the bus per grant (1..255)
MIN_GAP, 4, CLK cycles the CPU keeps the bus after release before a new request is issued (0..255; 0 = no gap)
ACK_TIMEOUT, 255, CLK cycles to wait for nBUSACK low before aborting the request (1..255)

Ports:
CLK  in  1  system clock, same as the Z80 core clock
nRESET  in  1  asynchronous active-low reset
dma_req  in  1  DMA wants the bus; level, held until dma_gnt or withdrawn
dma_done  in  1  DMA finished early; single-cycle pulse, valid only while dma_gnt=1
nBUSACK  in  1  from the Z80 nBUSACK pin; synchronous to CLK, no synchroniser
nBUSRQ  out  1  to the Z80 nBUSRQ pin; registered
dma_gnt  out  1  DMA owns the bus and may drive it; registered
bus_sel  out  1  mux select: 1 = DMA drives A/D/control, 0 = Z80; registered, always equals dma_gnt
burst_cnt  out  8  cycles used in the current grant; 0 outside GRANT
timeout_err  out  1  sticky; set when the Z80 did not acknowledge within ACK_TIMEOUT
err_clr  in  1  synchronous clear of timeout_err

Behaviour:
- Reset (nRESET=0, asynchronous):
  - Outputs: nBUSRQ=1, dma_gnt=0, bus_sel=0, burst_cnt=0, timeout_err=0.
  - State=IDLE; all counters cleared.
  - Reset asserted mid-grant drops bus_sel immediately. The Z80 regains the bus through its own reset.
- All outputs are registered. In the rules below, "after edge k" means the value is visible in the cycle following rising edge k.
- IDLE:
  - dma_req=1 at edge k -> REQ; nBUSRQ=0 after edge k.
- REQ:
  - Wait counter starts at 0 and increments each cycle.
  - nBUSACK=0 at edge m -> GRANT; dma_gnt=1, bus_sel=1, burst_cnt=1 after edge m.
  - dma_req=0 before acknowledge -> TURN (request withdrawn, no grant).
  - Wait counter reaches ACK_TIMEOUT with nBUSACK still 1 -> set timeout_err, go to TURN.
  - If dma_req=0 and nBUSACK=0 are sampled on the same edge, withdrawal wins -> TURN. No grant is issued.
- GRANT:
  - burst_cnt increments each cycle and saturates at MAX_BURST.
  - Exit when any of the following is true: dma_req=0, dma_done=1, or burst_cnt==MAX_BURST.
  - On exit: dma_gnt=0 and bus_sel=0 on the next edge; nBUSRQ stays 0; go to TURN.
  - If the Z80 raises nBUSACK during GRANT (protocol violation): exit the same way, and do not set the error.
- TURN:
  - Exactly 1 cycle, so the DMA stops driving before the Z80 reclaims the bus.
  - nBUSRQ=1 after the TURN edge; go to RELEASE.
- RELEASE:
  - Wait for nBUSACK=1, with no timeout. Then go to GAP, or to IDLE when MIN_GAP=0.
- GAP:
  - Count MIN_GAP cycles, then go to IDLE.
  - dma_req is ignored in GAP; a held request is serviced from IDLE afterwards.
- Burst length: with dma_req held, dma_gnt is high for exactly MAX_BURST cycles.
- Back-to-back grants: dma_gnt falling edge to the next nBUSRQ falling edge is at least MIN_GAP+2 cycles plus the Z80 release latency.
- timeout_err:
  - err_clr=1 clears it.
  - If a new timeout and err_clr occur on the same edge, set wins.
- Invariants (to be asserted by the bench):
  - Never dma_gnt=1 while nBUSACK=1, except during the single exit cycle of a violation.
  - Never dma_gnt=1 while nBUSRQ=1.
  - bus_sel==dma_gnt at all times.

Test Plan:
- Basic grant: dma_req=1 at edge 2, Z80 model acks 3 cycles later, dma_done pulse in the 5th grant cycle -> nBUSRQ low after edge 2; dma_gnt high for exactly 5 cycles; nBUSRQ high 1 cycle after dma_gnt falls; GAP of 4 cycles observed.
- Burst limit: MAX_BURST=16, dma_req held high throughout -> dma_gnt high 16 cycles; burst_cnt runs 1..16; then TURN, RELEASE, 4-cycle GAP; new nBUSRQ low on the first IDLE edge.
- Timeout: ACK_TIMEOUT=8, nBUSACK held 1 -> after 8 REQ cycles, timeout_err=1, no grant, nBUSRQ returns 1. Pulse err_clr -> timeout_err=0. Drive err_clr on the same edge as a second timeout -> timeout_err stays 1.
- Withdrawal race: dma_req dropped on the same edge nBUSACK falls -> dma_gnt never asserts; nBUSRQ returns 1 via TURN.
- Async reset mid-grant: nRESET low during GRANT cycle 3 -> nBUSRQ=1, dma_gnt=0, bus_sel=0 immediately without waiting for a clock edge. After release, a new dma_req gets a normal grant.
- MIN_GAP=0, continuous dma_req -> RELEASE goes straight to IDLE; the next nBUSRQ falls 1 cycle after nBUSACK rises.
